// File: rtl/scoreboard_ctrl.sv
// rtl/scoreboard_ctrl.sv - busy-bit array sequencer with hazard checks and writeback clear queue
module scoreboard_ctrl #(
    parameter int CLR_DEPTH  = 4,
    parameter bit INIT_SWEEP = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       issue_valid,
    input  logic [2:0] issue_sr1,
    input  logic [2:0] issue_sr2,
    input  logic [2:0] issue_dr,
    input  logic       issue_sr1_used,
    input  logic       issue_sr2_used,
    input  logic       issue_dr_used,
    output logic       issue_ready,
    output logic       hazard_stall,
    input  logic       wb_valid,
    input  logic [2:0] wb_dr,
    output logic       wb_ready,
    output logic       sr_enable,
    output logic       sr_set,
    output logic       sr_reset,
    output logic [2:0] sr_index,
    input  logic       sr_dataout,
    output logic       ctrl_busy
);
    localparam int          PW       = $clog2(CLR_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(CLR_DEPTH);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHK1,
        ST_CHK2,
        ST_CHK3,
        ST_COMMIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    sweep_cnt;

    logic [2:0]    q_mem [CLR_DEPTH];
    logic [PW-1:0] q_head;
    logic [PW-1:0] q_tail;
    logic [PW:0]   q_count;
    logic          q_empty;
    logic          q_full;
    logic          q_push;
    logic          q_pop;

    assign q_empty   = (q_count == '0);
    assign q_full    = (q_count == FULL_CNT);
    // Queue drains whenever it holds anything, except while the sweep owns the port.
    assign q_pop     = !q_empty && (state != ST_INIT);
    assign q_push    = wb_valid && wb_ready;
    assign wb_ready  = reset_n && (state != ST_INIT) && !q_full;
    assign ctrl_busy = reset_n && (state != ST_IDLE);

    // State register and init sweep counter; the FSM holds while the queue owns the port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT_SWEEP ? ST_INIT : ST_IDLE;
            sweep_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                sweep_cnt <= sweep_cnt + 3'd1;
            end
        end
    end

    // Clear queue pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (q_push) begin
                q_tail <= q_tail + 1'b1;
            end
            if (q_pop) begin
                q_head <= q_head + 1'b1;
            end
            if (q_push && !q_pop) begin
                q_count <= q_count + 1'b1;
            end else if (q_pop && !q_push) begin
                q_count <= q_count - 1'b1;
            end
        end
    end

    // Clear queue storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_mem[q_tail] <= wb_dr;
        end
    end

    // Port arbitration: sweep, then pending clears, then the issue sequence.
    always_comb begin
        state_nxt    = state;
        sr_enable    = 1'b0;
        sr_set       = 1'b0;
        sr_reset     = 1'b0;
        sr_index     = 3'd0;
        issue_ready  = 1'b0;
        hazard_stall = 1'b0;
        if (state == ST_INIT) begin
            sr_enable = 1'b1;
            sr_reset  = 1'b1;
            sr_index  = sweep_cnt;
            if (sweep_cnt == 3'd7) begin
                state_nxt = ST_IDLE;
            end
        end else if (!q_empty) begin
            sr_enable = 1'b1;
            sr_reset  = 1'b1;
            sr_index  = q_mem[q_head];
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_valid) begin
                        state_nxt = ST_CHK1;
                    end
                end
                ST_CHK1: begin
                    sr_index = issue_sr1;
                    if (issue_sr1_used && sr_dataout) begin
                        hazard_stall = 1'b1;
                    end else begin
                        state_nxt = ST_CHK2;
                    end
                end
                ST_CHK2: begin
                    sr_index = issue_sr2;
                    if (issue_sr2_used && sr_dataout) begin
                        hazard_stall = 1'b1;
                    end else begin
                        state_nxt = ST_CHK3;
                    end
                end
                ST_CHK3: begin
                    sr_index = issue_dr;
                    if (issue_dr_used && sr_dataout) begin
                        hazard_stall = 1'b1;
                    end else begin
                        state_nxt = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    issue_ready = 1'b1;
                    state_nxt   = ST_IDLE;
                    if (issue_dr_used) begin
                        sr_enable = 1'b1;
                        sr_set    = 1'b1;
                        sr_index  = issue_dr;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        // Outputs are forced low the moment reset is asserted, not at the next edge.
        if (!reset_n) begin
            sr_enable    = 1'b0;
            sr_set       = 1'b0;
            sr_reset     = 1'b0;
            sr_index     = 3'd0;
            issue_ready  = 1'b0;
            hazard_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb/tb_scoreboard_ctrl.sv - randomized self-checking bench for scoreboard_ctrl
module tb_scoreboard_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       issue_valid;
    logic [2:0] issue_sr1, issue_sr2, issue_dr;
    logic       issue_sr1_used, issue_sr2_used, issue_dr_used;
    logic       issue_ready, hazard_stall;
    logic       wb_valid;
    logic [2:0] wb_dr;
    logic       wb_ready;
    logic       sr_enable, sr_set, sr_reset;
    logic [2:0] sr_index;
    logic       sr_dataout;
    logic       ctrl_busy;

    logic [7:0] busy_arr = 8'h00;
    logic       scramble = 1'b0;
    logic [7:0] scramble_val = 8'h00;

    int checks = 0;
    int errors = 0;

    scoreboard_ctrl #(.CLR_DEPTH(DEPTH), .INIT_SWEEP(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_sr1(issue_sr1), .issue_sr2(issue_sr2), .issue_dr(issue_dr),
        .issue_sr1_used(issue_sr1_used), .issue_sr2_used(issue_sr2_used), .issue_dr_used(issue_dr_used),
        .issue_ready(issue_ready), .hazard_stall(hazard_stall),
        .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_ready(wb_ready),
        .sr_enable(sr_enable), .sr_set(sr_set), .sr_reset(sr_reset), .sr_index(sr_index),
        .sr_dataout(sr_dataout), .ctrl_busy(ctrl_busy)
    );

    always #5 clk = ~clk;

    // Busy-bit array with no reset; scramble emulates its arbitrary power-up contents.
    assign sr_dataout = busy_arr[sr_index];
    always @(posedge clk) begin
        if (scramble) busy_arr <= scramble_val;
        else if (sr_enable && sr_set) busy_arr[sr_index] <= 1'b1;
        else if (sr_enable && sr_reset) busy_arr[sr_index] <= 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string n, input int en, input int st, input int rs,
                       input int idx, input int rdy, input int stall);
        chk({n, ".sr_enable"}, int'(sr_enable), en);
        chk({n, ".sr_set"}, int'(sr_set), st);
        chk({n, ".sr_reset"}, int'(sr_reset), rs);
        chk({n, ".issue_ready"}, int'(issue_ready), rdy);
        chk({n, ".hazard_stall"}, int'(hazard_stall), stall);
        if (idx >= 0) chk({n, ".sr_index"}, int'(sr_index), idx);
    endtask

    task automatic set_issue(input logic v, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                             input logic u1, input logic u2, input logic ud);
        issue_valid = v; issue_sr1 = s1; issue_sr2 = s2; issue_dr = d;
        issue_sr1_used = u1; issue_sr2_used = u2; issue_dr_used = ud;
    endtask

    // Reference model: sweep position, issue step (0 idle, 1..3 checks, 4 accept) and a FIFO of clears.
    bit  m_init = 1'b1;
    int  m_sweep = 0;
    int  m_phase = 0;
    int  m_q[$];
    bit  e_en, e_set, e_rst, e_rdy, e_stall, e_wbr, e_busy;
    int  e_idx;
    bit  c_push, c_iv;
    int  c_dr;

    function automatic int fld(input int ph);
        if (ph == 1) return int'(issue_sr1);
        if (ph == 2) return int'(issue_sr2);
        return int'(issue_dr);
    endfunction

    function automatic bit fld_used(input int ph);
        if (ph == 1) return issue_sr1_used;
        if (ph == 2) return issue_sr2_used;
        return issue_dr_used;
    endfunction

    // Compare every cycle at the falling edge, advance the model at the rising edge.
    always begin
        @(negedge clk);
        e_en = 0; e_set = 0; e_rst = 0; e_rdy = 0; e_stall = 0; e_wbr = 0; e_busy = 0; e_idx = -1;
        if (reset_n) begin
            e_wbr  = !m_init && (m_q.size() < DEPTH);
            e_busy = m_init || (m_phase != 0);
            if (m_init) begin
                e_en = 1; e_rst = 1; e_idx = m_sweep;
            end else if (m_q.size() > 0) begin
                e_en = 1; e_rst = 1; e_idx = m_q[0];
            end else if (m_phase >= 1 && m_phase <= 3) begin
                e_idx   = fld(m_phase);
                e_stall = fld_used(m_phase) && busy_arr[e_idx];
            end else if (m_phase == 4) begin
                e_rdy = 1;
                if (issue_dr_used) begin
                    e_en = 1; e_set = 1; e_idx = int'(issue_dr);
                end
            end
        end
        chk("m.sr_enable", int'(sr_enable), int'(e_en));
        chk("m.sr_set", int'(sr_set), int'(e_set));
        chk("m.sr_reset", int'(sr_reset), int'(e_rst));
        chk("m.issue_ready", int'(issue_ready), int'(e_rdy));
        chk("m.hazard_stall", int'(hazard_stall), int'(e_stall));
        chk("m.wb_ready", int'(wb_ready), int'(e_wbr));
        chk("m.ctrl_busy", int'(ctrl_busy), int'(e_busy));
        if (e_idx >= 0) chk("m.sr_index", int'(sr_index), e_idx);
        c_push = wb_valid && e_wbr;
        c_dr   = int'(wb_dr);
        c_iv   = issue_valid;
        @(posedge clk);
        if (!reset_n) begin
            m_init = 1'b1; m_sweep = 0; m_phase = 0; m_q.delete();
        end else begin
            if (m_init) begin
                if (m_sweep == 7) m_init = 1'b0;
                m_sweep = m_sweep + 1;
            end else if (m_q.size() > 0) begin
                void'(m_q.pop_front());
            end else if (m_phase == 0) begin
                if (c_iv) m_phase = 1;
            end else if (m_phase == 4) begin
                m_phase = 0;
            end else if (!e_stall) begin
                m_phase = m_phase + 1;
            end
            if (c_push) m_q.push_back(c_dr);
        end
    end

    task automatic sweep_checks(input string n);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lit(n, 1, 0, 1, i, 0, 0);
            chk({n, ".wb_ready"}, int'(wb_ready), 0);
            chk({n, ".ctrl_busy"}, int'(ctrl_busy), 1);
        end
        @(negedge clk);
        lit({n, "_idle"}, 0, 0, 0, -1, 0, 0);
        chk({n, "_idle.ctrl_busy"}, int'(ctrl_busy), 0);
        chk({n, "_idle.wb_ready"}, int'(wb_ready), 1);
    endtask

    initial begin : main
        bit ir, wr;
        reset_n = 1'b0; wb_valid = 1'b0; wb_dr = 3'd0;
        set_issue(0, 0, 0, 0, 0, 0, 0);
        scramble = 1'b1; scramble_val = 8'hff;
        #2;
        lit("reset", 0, 0, 0, -1, 0, 0);
        chk("reset.wb_ready", int'(wb_ready), 0);
        chk("reset.ctrl_busy", int'(ctrl_busy), 0);
        repeat (2) @(posedge clk);
        #1; scramble = 1'b0; reset_n = 1'b1;
        sweep_checks("sweep");

        // Hazard-free issue: reads R1, R2, R3, then accept with set of R3.
        @(posedge clk); #1; set_issue(1, 1, 2, 3, 1, 1, 1);
        @(negedge clk); lit("t2_idle", 0, 0, 0, -1, 0, 0);
        @(negedge clk); lit("t2_chk1", 0, 0, 0, 1, 0, 0);
        @(negedge clk); lit("t2_chk2", 0, 0, 0, 2, 0, 0);
        @(negedge clk); lit("t2_chk3", 0, 0, 0, 3, 0, 0);
        @(negedge clk); lit("t2_commit", 1, 1, 0, 3, 1, 0);

        // RAW on R3: stall until a clear of R3 is drained.
        @(posedge clk); #1; set_issue(1, 3, 0, 0, 1, 0, 0);
        @(negedge clk); lit("t3_idle", 0, 0, 0, -1, 0, 0);
        @(negedge clk); lit("t3_stall1", 0, 0, 0, 3, 0, 1);
        @(negedge clk); lit("t3_stall2", 0, 0, 0, 3, 0, 1);
        @(posedge clk); #1; wb_valid = 1'b1; wb_dr = 3'd3;
        @(negedge clk); lit("t3_stall3", 0, 0, 0, 3, 0, 1);
        chk("t3.wb_ready", int'(wb_ready), 1);
        @(posedge clk); #1; wb_valid = 1'b0;
        @(negedge clk); lit("t3_drain", 1, 0, 1, 3, 0, 0);
        @(negedge clk); lit("t3_pass", 0, 0, 0, 3, 0, 0);
        @(negedge clk); lit("t3_chk2", 0, 0, 0, -1, 0, 0);
        @(negedge clk); lit("t3_chk3", 0, 0, 0, -1, 0, 0);
        @(negedge clk); lit("t3_commit", 0, 0, 0, -1, 1, 0);

        // Clear pushed during CHK1 drains in the first CHK2 cycle; latency becomes 5.
        @(posedge clk); #1; set_issue(1, 4, 5, 6, 1, 1, 1);
        @(negedge clk); lit("t5_idle", 0, 0, 0, -1, 0, 0);
        @(posedge clk); #1; wb_valid = 1'b1; wb_dr = 3'd7;
        @(negedge clk); lit("t5_chk1", 0, 0, 0, 4, 0, 0);
        @(posedge clk); #1; wb_valid = 1'b0;
        @(negedge clk); lit("t5_drain", 1, 0, 1, 7, 0, 0);
        chk("t5_drain.ctrl_busy", int'(ctrl_busy), 1);
        @(negedge clk); lit("t5_chk2", 0, 0, 0, 5, 0, 0);
        @(negedge clk); lit("t5_chk3", 0, 0, 0, 6, 0, 0);
        @(negedge clk); lit("t5_commit", 1, 1, 0, 6, 1, 0);

        // WAW on R6 holds CHK3; reset with a clear queued aborts everything and reruns the sweep.
        @(posedge clk); #1; set_issue(1, 0, 1, 6, 1, 1, 1);
        @(negedge clk); lit("t6_idle", 0, 0, 0, -1, 0, 0);
        @(negedge clk); lit("t6_chk1", 0, 0, 0, 0, 0, 0);
        @(negedge clk); lit("t6_chk2", 0, 0, 0, 1, 0, 0);
        @(negedge clk); lit("t6_waw1", 0, 0, 0, 6, 0, 1);
        @(posedge clk); #1; wb_valid = 1'b1; wb_dr = 3'd5;
        @(negedge clk); lit("t6_waw2", 0, 0, 0, 6, 0, 1);
        @(posedge clk); #1;
        reset_n = 1'b0; wb_valid = 1'b0; issue_valid = 1'b0;
        scramble = 1'b1; scramble_val = 8'h5a;
        #1;
        lit("t6_reset", 0, 0, 0, 0, 0, 0);
        chk("t6_reset.wb_ready", int'(wb_ready), 0);
        chk("t6_reset.ctrl_busy", int'(ctrl_busy), 0);
        @(posedge clk); #1; reset_n = 1'b1; scramble = 1'b0;
        sweep_checks("resweep");

        // Randomized traffic with protocol-respecting holds and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ir = issue_ready;
            wr = wb_ready;
            @(posedge clk); #1;
            if (!reset_n) begin
                reset_n = 1'b1; scramble = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0;
                scramble = 1'b1; scramble_val = 8'($urandom);
                continue;
            end
            if (!issue_valid || ir) begin
                set_issue($urandom_range(0, 99) < 60, 3'($urandom), 3'($urandom), 3'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            end
            if (!(wb_valid && !wr)) begin
                wb_valid = $urandom_range(0, 99) < 35;
                wb_dr    = 3'($urandom);
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
